// File: rtl/issue_scoreboard.sv
// ============================================================================
// Module   : issue_scoreboard
// Brief    : In-order issue control with a register scoreboard, MDU occupancy
//            counter and branch hold.
// Revision : 1.0
// ============================================================================
`default_nettype none

module issue_scoreboard #(
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        rs1_use,
    input  logic        rs2_use,
    input  logic        rd_use,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic        mdu_op,
    input  logic        is_branch,
    input  logic        ex_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic        br_resolve,
    input  logic        br_taken,
    output logic        id_ready,
    output logic        issue_valid,
    output logic        flush,
    output logic        stall_hazard,
    output logic [31:0] busy_mask
);

    localparam logic [3:0] C_MDU_LAT = 4'(MDU_LATENCY);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_WAIT_BR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [3:0]  mdu_cnt_q, mdu_cnt_d;

    logic [31:0] w_clr_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_busy_eff;
    logic        w_hazard;
    logic        w_mdu_block;
    logic        w_issue;

    always_comb begin
        // A register retiring this cycle is already treated as free.
        w_clr_mask  = wb_valid ? (32'd1 << wb_addr) : 32'd0;
        w_busy_eff  = busy_q & ~w_clr_mask;
        w_hazard    = (rs1_use & w_busy_eff[rs1_addr])
                    | (rs2_use & w_busy_eff[rs2_addr])
                    | (rd_use  & w_busy_eff[rd_addr]);
        w_mdu_block = mdu_op & (mdu_cnt_q != 4'd0);
        w_issue     = (state_q == ST_RUN) & id_valid & ex_ready
                    & ~w_hazard & ~w_mdu_block;
        w_set_mask  = (w_issue & rd_use & (rd_addr != 5'd0))
                    ? (32'd1 << rd_addr) : 32'd0;

        busy_d      = (w_busy_eff | w_set_mask) & 32'hFFFF_FFFE;

        mdu_cnt_d   = mdu_cnt_q;
        if (w_issue && mdu_op) begin
            mdu_cnt_d = C_MDU_LAT;
        end else if (mdu_cnt_q != 4'd0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end

        state_d     = state_q;
        flush       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (w_issue && is_branch) begin
                    state_d = ST_WAIT_BR;
                end
            end
            ST_WAIT_BR: begin
                if (br_resolve) begin
                    flush   = br_taken;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        issue_valid  = w_issue;
        id_ready     = w_issue;
        stall_hazard = id_valid & (state_q == ST_RUN) & (w_hazard | w_mdu_block);
        busy_mask    = busy_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            busy_q    <= 32'd0;
            mdu_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// ============================================================================
// Module   : tb_issue_scoreboard
// Brief    : Directed vectors for issue_scoreboard with hand-computed results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_issue_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid, rs1_use, rs2_use, rd_use;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        mdu_op, is_branch, ex_ready, wb_valid;
    logic [4:0]  wb_addr;
    logic        br_resolve, br_taken;
    logic        id_ready, issue_valid, flush, stall_hazard;
    logic [31:0] busy_mask;

    int n_vec = 0;
    int n_err = 0;

    issue_scoreboard #(.MDU_LATENCY(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .rs1_use      (rs1_use),
        .rs2_use      (rs2_use),
        .rd_use       (rd_use),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_addr      (rd_addr),
        .mdu_op       (mdu_op),
        .is_branch    (is_branch),
        .ex_ready     (ex_ready),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .br_resolve   (br_resolve),
        .br_taken     (br_taken),
        .id_ready     (id_ready),
        .issue_valid  (issue_valid),
        .flush        (flush),
        .stall_hazard (stall_hazard),
        .busy_mask    (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_valid = 0; rs1_use = 0; rs2_use = 0; rd_use = 0;
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
        mdu_op = 0; is_branch = 0; ex_ready = 1;
        wb_valid = 0; wb_addr = 0; br_resolve = 0; br_taken = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        clr_in();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        settle();
        chk("rst_busy",  busy_mask, 32'h0);
        chk("rst_issue", {31'b0, issue_valid}, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'h0);

        // RAW stall and writeback bypass
        step(); clr_in();
        id_valid = 1; rd_use = 1; rd_addr = 5'd5; settle();
        chk("raw_prod_issue", {31'b0, issue_valid}, 32'h1);
        step(); clr_in();
        id_valid = 1; rs1_use = 1; rs1_addr = 5'd5; settle();
        chk("raw_busy5", busy_mask, 32'h0000_0020);
        chk("raw_stall", {31'b0, stall_hazard}, 32'h1);
        chk("raw_noissue", {31'b0, issue_valid}, 32'h0);
        step();
        settle();
        chk("raw_still_stall", {31'b0, issue_valid}, 32'h0);
        wb_valid = 1; wb_addr = 5'd5; settle();
        chk("raw_bypass_issue", {31'b0, issue_valid}, 32'h1);
        chk("raw_bypass_nostall", {31'b0, stall_hazard}, 32'h0);
        step(); clr_in(); settle();
        chk("raw_bit5_clear", busy_mask, 32'h0);

        // x0 never marked busy
        id_valid = 1; rd_use = 1; rd_addr = 5'd0; settle();
        chk("x0_issue", {31'b0, issue_valid}, 32'h1);
        step(); clr_in(); settle();
        chk("x0_busy", busy_mask, 32'h0);

        // WAW stall, then set wins over simultaneous clear
        id_valid = 1; rd_use = 1; rd_addr = 5'd7; settle();
        step(); clr_in();
        id_valid = 1; rd_use = 1; rd_addr = 5'd7; settle();
        chk("waw_busy7", busy_mask, 32'h0000_0080);
        chk("waw_stall", {31'b0, issue_valid}, 32'h0);
        wb_valid = 1; wb_addr = 5'd7; settle();
        chk("setwin_issue", {31'b0, issue_valid}, 32'h1);
        step(); clr_in(); settle();
        chk("setwin_bit7", busy_mask, 32'h0000_0080);
        wb_valid = 1; wb_addr = 5'd7;
        step(); clr_in(); settle();
        chk("wb7_clear", busy_mask, 32'h0);

        // MDU sequencing: issue at N, ALU at N+1, next MDU op at N+5
        id_valid = 1; mdu_op = 1; settle();
        chk("mdu0_issue", {31'b0, issue_valid}, 32'h1);
        step(); clr_in();
        id_valid = 1; settle();
        chk("mdu_alu_issue", {31'b0, issue_valid}, 32'h1);
        for (int k = 2; k <= 5; k++) begin
            step(); clr_in();
            id_valid = 1; mdu_op = 1; settle();
            chk($sformatf("mdu_n%0d_issue", k), {31'b0, issue_valid}, (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("mdu_n%0d_stall", k), {31'b0, stall_hazard}, (k == 5) ? 32'h0 : 32'h1);
        end
        step(); clr_in();

        // Branch taken
        id_valid = 1; is_branch = 1; settle();
        chk("br_issue", {31'b0, issue_valid}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            step(); clr_in();
            id_valid = 1;
            if (k == 3) begin br_resolve = 1; br_taken = 1; end
            settle();
            chk($sformatf("brt_hold%0d", k), {31'b0, id_ready}, 32'h0);
            chk($sformatf("brt_flush%0d", k), {31'b0, flush}, (k == 3) ? 32'h1 : 32'h0);
        end
        step(); clr_in();
        id_valid = 1; settle();
        chk("brt_resume", {31'b0, id_ready}, 32'h1);
        chk("brt_flush_once", {31'b0, flush}, 32'h0);

        // Branch not taken
        step(); clr_in();
        id_valid = 1; is_branch = 1; settle();
        step(); clr_in();
        id_valid = 1; br_resolve = 1; br_taken = 0; settle();
        chk("brn_flush", {31'b0, flush}, 32'h0);
        chk("brn_hold", {31'b0, id_ready}, 32'h0);
        step(); clr_in();
        id_valid = 1; settle();
        chk("brn_resume", {31'b0, id_ready}, 32'h1);

        // Stray resolve in RUN
        step(); clr_in();
        br_resolve = 1; br_taken = 1; settle();
        chk("run_resolve_flush", {31'b0, flush}, 32'h0);

        // Back-pressure
        step(); clr_in();
        id_valid = 1; rd_use = 1; rd_addr = 5'd9; ex_ready = 0; settle();
        chk("bp_noissue", {31'b0, issue_valid}, 32'h0);
        chk("bp_nostall", {31'b0, stall_hazard}, 32'h0);
        step(); clr_in(); settle();
        chk("bp_busy", busy_mask, 32'h0);

        // Reset while in WAIT_BR with bits set and MDU busy
        id_valid = 1; mdu_op = 1; rd_use = 1; rd_addr = 5'd3;
        step(); clr_in();
        id_valid = 1; is_branch = 1; rd_use = 1; rd_addr = 5'd1; settle();
        chk("rstwb_br_issue", {31'b0, issue_valid}, 32'h1);
        step(); clr_in();
        id_valid = 1; settle();
        chk("rstwb_busy", busy_mask, 32'h0000_000A);
        chk("rstwb_hold", {31'b0, id_ready}, 32'h0);
        clr_in(); rst = 1;
        step();
        rst = 0;
        id_valid = 1; mdu_op = 1; rs1_use = 1; rs1_addr = 5'd3; settle();
        chk("rstwb_busy0", busy_mask, 32'h0);
        chk("rstwb_reissue", {31'b0, issue_valid}, 32'h1);
        step(); clr_in();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
